// File: rtl/hyper_txn_sequencer.sv
// rtl/hyper_txn_sequencer.sv - HyperBus transaction phase sequencer
// Runs one burst at a time through CS, CA, write latency, data counting and CS-high recovery.
module hyper_txn_sequencer #(
    parameter int NB_CS = 2,
    parameter int LEN_W = 16,
    parameter int TO_W  = 8
) (
    input  logic             sys_clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic             req_cs_i,
    input  logic [31:0]      req_addr_i,
    input  logic [LEN_W-1:0] req_len_i,
    input  logic [4:0]       cfg_latency_i,
    input  logic [3:0]       cfg_csh_i,
    input  logic [TO_W-1:0]  cfg_rd_timeout_i,
    output logic [NB_CS-1:0] phy_cs_n_o,
    output logic             phy_ck_en_o,
    output logic             phy_ca_valid_o,
    output logic [15:0]      phy_ca_o,
    output logic             phy_oe_o,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    input  logic             rx_valid_i,
    output logic             done_o,
    output logic             err_o
);

    localparam int CNT_W = (TO_W > 5) ? TO_W : 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CA,
        S_LAT,
        S_WDATA,
        S_RDATA,
        S_CSH
    } state_t;

    state_t state, state_nxt;

    logic             write_q;
    logic             cs_q;
    logic [31:0]      addr_q;
    logic [LEN_W-1:0] wcnt;
    logic [4:0]       lat_q;
    logic [3:0]       csh_q;
    logic [TO_W-1:0]  to_q;
    logic [1:0]       ca_cnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             csh_first;
    logic             err_q;
    logic             cs_act;
    logic [NB_CS-1:0] cs_sel;
    logic [47:0]      ca_word;

    assign cnt_inc = cnt + CNT_W'(1);
    assign cs_sel  = NB_CS'(1) << cs_q;
    assign ca_word = {~write_q, 1'b0, 1'b1, addr_q[31:3], 13'd0, addr_q[2:0]};

    // cs_n is decoded from the state so an asynchronous reset releases it immediately
    assign phy_cs_n_o = cs_act ? ~cs_sel : '1;
    assign done_o     = (state == S_CSH) && csh_first;
    assign err_o      = done_o && err_q;

    always_comb begin
        state_nxt      = state;
        req_ready_o    = 1'b0;
        cs_act         = 1'b0;
        phy_ck_en_o    = 1'b0;
        phy_ca_valid_o = 1'b0;
        phy_ca_o       = 16'd0;
        phy_oe_o       = 1'b0;
        tx_ready_o     = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_nxt = S_CA;
            end
            S_CA: begin
                cs_act         = 1'b1;
                phy_ca_valid_o = 1'b1;
                phy_oe_o       = 1'b1;
                phy_ck_en_o    = 1'b1;
                case (ca_cnt)
                    2'd0:    phy_ca_o = ca_word[47:32];
                    2'd1:    phy_ca_o = ca_word[31:16];
                    default: phy_ca_o = ca_word[15:0];
                endcase
                if (ca_cnt == 2'd2) begin
                    if (!write_q)          state_nxt = S_RDATA;
                    else if (lat_q != '0)  state_nxt = S_LAT;
                    else                   state_nxt = S_WDATA;
                end
            end
            S_LAT: begin
                cs_act      = 1'b1;
                phy_ck_en_o = 1'b1;
                if (cnt_inc == CNT_W'(lat_q)) state_nxt = S_WDATA;
            end
            S_WDATA: begin
                cs_act      = 1'b1;
                phy_oe_o    = 1'b1;
                phy_ck_en_o = tx_valid_i;
                tx_ready_o  = tx_valid_i;
                if (tx_valid_i && wcnt == '0) state_nxt = S_CSH;
            end
            S_RDATA: begin
                cs_act      = 1'b1;
                phy_ck_en_o = 1'b1;
                if (rx_valid_i) begin
                    if (wcnt == '0) state_nxt = S_CSH;
                end else if (to_q != '0 && cnt_inc == CNT_W'(to_q)) begin
                    state_nxt = S_CSH;
                end
            end
            S_CSH: begin
                if (cnt_inc >= CNT_W'(csh_q)) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            write_q   <= 1'b0;
            cs_q      <= 1'b0;
            addr_q    <= '0;
            wcnt      <= '0;
            lat_q     <= '0;
            csh_q     <= '0;
            to_q      <= '0;
            ca_cnt    <= '0;
            cnt       <= '0;
            csh_first <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    ca_cnt <= '0;
                    cnt    <= '0;
                    if (req_valid_i) begin
                        write_q <= req_write_i;
                        cs_q    <= req_cs_i;
                        addr_q  <= req_addr_i;
                        wcnt    <= (req_len_i == '0) ? '0 : req_len_i - LEN_W'(1);
                        lat_q   <= cfg_latency_i;
                        csh_q   <= cfg_csh_i;
                        to_q    <= cfg_rd_timeout_i;
                    end
                end
                S_CA: begin
                    ca_cnt <= ca_cnt + 2'd1;
                    cnt    <= '0;
                end
                S_LAT: cnt <= cnt_inc;
                S_WDATA: begin
                    if (tx_valid_i) wcnt <= wcnt - LEN_W'(1);
                end
                S_RDATA: begin
                    // the idle counter restarts on every captured word
                    if (rx_valid_i) begin
                        wcnt <= wcnt - LEN_W'(1);
                        cnt  <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_CSH: begin
                    cnt       <= cnt_inc;
                    csh_first <= 1'b0;
                end
                default: cnt <= '0;
            endcase
            if (state_nxt == S_CSH && state != S_CSH) begin
                cnt       <= '0;
                csh_first <= 1'b1;
                err_q     <= (state == S_RDATA) && !rx_valid_i;
            end
        end
    end

endmodule

// File: tb/tb_hyper_txn_sequencer.sv
// tb/tb_hyper_txn_sequencer.sv - directed scoreboard bench for hyper_txn_sequencer
module tb_hyper_txn_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_cs;
    logic [31:0] req_addr;
    logic [15:0] req_len;
    logic [4:0]  cfg_latency;
    logic [3:0]  cfg_csh;
    logic [7:0]  cfg_rd_timeout;
    logic [1:0]  cs_n;
    logic        ck_en, ca_valid, oe, tx_valid, tx_ready, rx_valid, done, err;
    logic [15:0] ca;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ca_cyc = 0;
    int done_cyc = 0;
    string tname = "reset";

    typedef struct {
        logic [15:0] ca0, ca1, ca2;
        logic [1:0]  csn;
        int quiet, words, stall, done_s, csh;
        logic err;
    } exp_t;

    exp_t exp_q[$];

    hyper_txn_sequencer dut (
        .sys_clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_cs_i(req_cs), .req_addr_i(req_addr), .req_len_i(req_len),
        .cfg_latency_i(cfg_latency), .cfg_csh_i(cfg_csh), .cfg_rd_timeout_i(cfg_rd_timeout),
        .phy_cs_n_o(cs_n), .phy_ck_en_o(ck_en), .phy_ca_valid_o(ca_valid), .phy_ca_o(ca),
        .phy_oe_o(oe), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .rx_valid_i(rx_valid),
        .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tname, tag, obs, expv);
        end
    endtask

    task automatic start_req(input logic w, input logic c, input logic [31:0] a, input logic [15:0] len,
                             input logic [4:0] lat, input logic [3:0] csh, input logic [7:0] to,
                             input int e_quiet, input int e_words, input int e_stall, input int e_done,
                             input logic e_err, input int e_csh, input logic push);
        exp_t e;
        req_write = w; req_cs = c; req_addr = a; req_len = len;
        cfg_latency = lat; cfg_csh = csh; cfg_rd_timeout = to;
        req_valid = 1'b1;
        if (push) begin
            e.ca0 = {~w, 1'b0, 1'b1, a[31:19]};
            e.ca1 = a[18:3];
            e.ca2 = {13'd0, a[2:0]};
            e.csn = 2'b11;
            e.csn[c] = 1'b0;
            e.quiet = e_quiet; e.words = e_words; e.stall = e_stall;
            e.done_s = e_done; e.err = e_err; e.csh = e_csh;
            exp_q.push_back(e);
        end
    endtask

    task automatic run_txn(input logic [63:0] tx_mask, input logic [63:0] rx_mask);
        exp_t e;
        int s = 0, first_ca = -1, ca_n = 0, quiet = 0, words = 0, stall = 0;
        int done_s = -1, cs_bad = 0, rdy_bad = 0, csh_n = 0;
        logic err_seen = 1'b0;
        logic cs_any = 1'b0;
        logic [1:0] cs_seen = 2'b11;
        logic [15:0] ca_seen[3];
        for (int i = 0; i < 3; i++) ca_seen[i] = 16'hxxxx;
        while (done_s < 0 && s < 200) begin
            @(posedge clk);
            @(negedge clk);
            s++;
            if (s == 1) begin
                // scramble request/config after accept; the burst must keep its latched values
                req_valid = 1'b0; cfg_latency = 5'd31; cfg_csh = 4'd15; cfg_rd_timeout = 8'd1;
            end
            tx_valid = (s < 64) ? tx_mask[s] : tx_mask[63];
            rx_valid = (s < 64) ? rx_mask[s] : rx_mask[63];
            #1;
            if (ca_valid) begin
                if (first_ca < 0) begin first_ca = s; ca_cyc = cyc; end
                if (ca_n < 3) ca_seen[ca_n] = ca;
                ca_n++;
            end
            if (cs_n != 2'b11) begin
                if (!cs_any) begin cs_seen = cs_n; cs_any = 1'b1; end
                else if (cs_n != cs_seen) cs_bad++;
                if (!ck_en) stall++;
                if (ck_en && !ca_valid && !oe) quiet++;
                if (req_ready) rdy_bad++;
            end
            if (tx_ready) words++;
            if (done) begin
                done_s = s; err_seen = err; done_cyc = cyc;
                if (cs_n != 2'b11) cs_bad++;
            end
        end
        if (done_s >= 0) begin
            csh_n = 1;
            while (csh_n < 40) begin
                @(posedge clk);
                @(negedge clk);
                #1;
                if (req_ready) break;
                csh_n++;
                if (cs_n != 2'b11 || done) cs_bad++;
            end
        end
        tx_valid = 1'b0;
        rx_valid = 1'b0;
        chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ca0", 32'(ca_seen[0]), 32'(e.ca0));
            chk("ca1", 32'(ca_seen[1]), 32'(e.ca1));
            chk("ca2", 32'(ca_seen[2]), 32'(e.ca2));
            chk("ca_cycles", ca_n, 3);
            chk("first_ca", first_ca, 1);
            chk("quiet_cycles", quiet, e.quiet);
            chk("words", words, e.words);
            chk("stall", stall, e.stall);
            chk("done_cycle", done_s, e.done_s);
            chk("err", 32'(err_seen), 32'(e.err));
            chk("cs_n", 32'(cs_seen), 32'(e.csn));
            chk("cs_glitch", cs_bad, 0);
            chk("ready_in_burst", rdy_bad, 0);
            chk("csh_cycles", csh_n, e.csh);
        end
    endtask

    initial begin
        int prev_done;
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_cs = 1'b0; req_addr = '0; req_len = '0;
        cfg_latency = '0; cfg_csh = '0; cfg_rd_timeout = '0;
        tx_valid = 1'b0; rx_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("cs_n", 32'(cs_n), 32'h3);
        chk("ready", 32'(req_ready), 32'h1);
        chk("ck_en", 32'(ck_en), 32'h0);
        chk("ca_valid", 32'(ca_valid), 32'h0);
        chk("ca", 32'(ca), 32'h0);
        chk("oe", 32'(oe), 32'h0);
        chk("tx_ready", 32'(tx_ready), 32'h0);
        chk("done", 32'(done), 32'h0);
        chk("err", 32'(err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        tname = "t1_write_lat6";
        start_req(1'b1, 1'b0, 32'h0000_1234, 16'd4, 5'd6, 4'd2, 8'd0, 6, 4, 0, 14, 1'b0, 2, 1'b1);
        chk("ca0_const", 32'(exp_q[0].ca0), 32'h2000);
        run_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'd0);

        tname = "t2_read_cs1";
        start_req(1'b0, 1'b1, 32'h0000_0008, 16'd3, 5'd6, 4'd1, 8'd5, 10, 0, 0, 14, 1'b0, 1, 1'b1);
        run_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'h3100);

        tname = "t3_read_timeout";
        start_req(1'b0, 1'b0, 32'h0010_0000, 16'd2, 5'd0, 4'd3, 8'd4, 5, 0, 0, 9, 1'b1, 3, 1'b1);
        run_txn(64'd0, 64'h10);

        tname = "t4_write_len0_stall";
        start_req(1'b1, 1'b1, 32'hFFFF_FFFF, 16'd0, 5'd0, 4'd0, 8'd3, 0, 1, 3, 8, 1'b0, 1, 1'b1);
        run_txn(~64'h70, 64'hFFFF_FFFF_FFFF_FFFF);

        tname = "t5_b2b_first";
        start_req(1'b1, 1'b0, 32'h0000_0040, 16'd1, 5'd0, 4'd0, 8'd0, 0, 1, 0, 5, 1'b0, 1, 1'b1);
        run_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        prev_done = done_cyc;
        tname = "t5_b2b_second";
        start_req(1'b0, 1'b1, 32'h0000_0002, 16'd1, 5'd0, 4'd0, 8'd0, 1, 0, 0, 5, 1'b0, 1, 1'b1);
        run_txn(64'd0, 64'h10);
        chk("done_to_ca", ca_cyc - prev_done, 2);

        tname = "t6_reset_mid_write";
        start_req(1'b1, 1'b0, 32'h0000_0100, 16'd4, 5'd0, 4'd1, 8'd0, 0, 0, 0, 0, 1'b0, 0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            tx_valid = 1'b1;
        end
        #1;
        chk("cs_n_active", 32'(cs_n), 32'h2);
        chk("tx_ready_active", 32'(tx_ready), 32'h1);
        rst = 1'b1;
        #1;
        chk("cs_n_rst", 32'(cs_n), 32'h3);
        chk("ready_rst", 32'(req_ready), 32'h1);
        chk("tx_ready_rst", 32'(tx_ready), 32'h0);
        chk("ck_en_rst", 32'(ck_en), 32'h0);
        chk("oe_rst", 32'(oe), 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("done_rst", 32'(done), 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        tx_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("ready_after", 32'(req_ready), 32'h1);
        chk("cs_n_after", 32'(cs_n), 32'h3);
        chk("done_after", 32'(done), 32'h0);

        tname = "t6_recover";
        start_req(1'b0, 1'b0, 32'h0000_0004, 16'd1, 5'd0, 4'd1, 8'd0, 1, 0, 0, 5, 1'b0, 1, 1'b1);
        run_txn(64'd0, 64'h10);

        tname = "end";
        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
